// File: rtl/mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory-side handshake signals around mem_arbiter.
// slave: arbiter view; master: the environment driving requesters and memory.
interface mem_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_rdata;
  logic        ifu_rsp_err;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_we;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rsp_rdata;
  logic        lsu_rsp_err;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_we, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
    output mem_req_valid, mem_addr, mem_wdata, mem_we, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_we, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
    input  mem_req_valid, mem_addr, mem_wdata, mem_we, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority (LSU over IFU) single-outstanding arbiter for the shared memory port.
// Optional transaction timeout with forced error response: define ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus,
  output logic           busy,
  output logic           owner
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  state_t state;

  logic done;
  logic timeout;
  logic fire;

  assign busy = (state != IDLE);
  assign done = (state == RSP) && bus.mem_rsp_valid;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] tmo_cnt;

  // Held at zero while idle so the count starts from zero on REQ entry.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) tmo_cnt <= '0;
    else                      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout = busy && (tmo_cnt == TMO) && !done;
`else
  assign timeout = 1'b0;
`endif

  assign fire = done || timeout;

  always_comb begin
    bus.lsu_req_ready = (state == IDLE) && bus.lsu_req_valid;
    bus.ifu_req_ready = (state == IDLE) && bus.ifu_req_valid && !bus.lsu_req_valid;
    bus.ifu_rsp_valid = fire && !owner;
    bus.lsu_rsp_valid = fire && owner;
    bus.ifu_rsp_err   = timeout && !owner;
    bus.lsu_rsp_err   = timeout && owner;
    bus.ifu_rsp_rdata = done ? bus.mem_rsp_rdata : '0;
    bus.lsu_rsp_rdata = done ? bus.mem_rsp_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      owner             <= 1'b0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_wdata     <= '0;
      bus.mem_we        <= 1'b0;
      bus.mem_wmask     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.lsu_req_valid) begin
            bus.mem_addr      <= bus.lsu_addr;
            bus.mem_wdata     <= bus.lsu_wdata;
            bus.mem_we        <= bus.lsu_we;
            bus.mem_wmask     <= bus.lsu_wmask;
            owner             <= 1'b1;
            bus.mem_req_valid <= 1'b1;
            state             <= REQ;
          end else if (bus.ifu_req_valid) begin
            bus.mem_addr      <= bus.ifu_addr;
            bus.mem_wdata     <= '0;
            bus.mem_we        <= 1'b0;
            bus.mem_wmask     <= '0;
            owner             <= 1'b0;
            bus.mem_req_valid <= 1'b1;
            state             <= REQ;
          end
        end
        REQ: begin
          if (timeout) begin
            bus.mem_req_valid <= 1'b0;
            state             <= IDLE;
          end else if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= RSP;
          end
        end
        RSP: begin
          if (fire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level reference model.
// Build with ARB_TIMEOUT_EN defined to exercise the timeout path (TIMEOUT_CYCLES = 8).
module tb_mem_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic owner;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .owner (owner)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: one optional outstanding transaction and its attributes.
  bit          m_open;
  bit          m_sent;
  bit          m_owner;
  bit          m_we;
  bit          m_wd_chk;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  int unsigned m_age;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit iv, input logic [31:0] ia,
                      input bit lv, input logic [31:0] la, input bit lwe,
                      input logic [31:0] lwd, input logic [3:0] lwm,
                      input bit mrdy, input bit mrv, input logic [31:0] mrd);
    bit done, tmo, fire;
    @(negedge clk);
    rst               = r;
    bus.ifu_req_valid = iv;
    bus.ifu_addr      = ia;
    bus.lsu_req_valid = lv;
    bus.lsu_addr      = la;
    bus.lsu_we        = lwe;
    bus.lsu_wdata     = lwd;
    bus.lsu_wmask     = lwm;
    bus.mem_req_ready = mrdy;
    bus.mem_rsp_valid = mrv;
    bus.mem_rsp_rdata = mrd;
    #1;
    done = m_open && m_sent && mrv;
`ifdef ARB_TIMEOUT_EN
    tmo = m_open && (m_age == TO) && !done;
`else
    tmo = 1'b0;
`endif
    fire = done || tmo;

    chk("busy",          32'(busy),              32'(m_open));
    chk("owner",         32'(owner),             32'(m_owner));
    chk("mem_req_valid", 32'(bus.mem_req_valid), 32'(m_open && !m_sent));
    chk("mem_addr",      bus.mem_addr,           m_addr);
    chk("mem_we",        32'(bus.mem_we),        32'(m_we));
    chk("mem_wmask",     32'(bus.mem_wmask),     32'(m_wmask));
    if (m_wd_chk) chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("lsu_req_ready", 32'(bus.lsu_req_ready), 32'(!m_open && lv));
    chk("ifu_req_ready", 32'(bus.ifu_req_ready), 32'(!m_open && iv && !lv));
    chk("ifu_rsp_valid", 32'(bus.ifu_rsp_valid), 32'(fire && !m_owner));
    chk("lsu_rsp_valid", 32'(bus.lsu_rsp_valid), 32'(fire && m_owner));
    chk("ifu_rsp_err",   32'(bus.ifu_rsp_err),   32'(tmo && !m_owner));
    chk("lsu_rsp_err",   32'(bus.lsu_rsp_err),   32'(tmo && m_owner));
    if (fire && !m_owner) chk("ifu_rsp_rdata", bus.ifu_rsp_rdata, done ? mrd : 32'h0);
    if (fire && m_owner && (tmo || !m_we))
      chk("lsu_rsp_rdata", bus.lsu_rsp_rdata, done ? mrd : 32'h0);

    if (r) begin
      m_open = 0; m_sent = 0; m_owner = 0; m_we = 0; m_wd_chk = 1;
      m_addr = '0; m_wdata = '0; m_wmask = '0; m_age = 0;
    end else if (!m_open) begin
      if (lv) begin
        m_open = 1; m_sent = 0; m_owner = 1; m_age = 0;
        m_addr = la; m_we = lwe; m_wdata = lwd; m_wmask = lwm; m_wd_chk = 1;
      end else if (iv) begin
        m_open = 1; m_sent = 0; m_owner = 0; m_age = 0;
        m_addr = ia; m_we = 0; m_wmask = '0; m_wd_chk = 0;
      end
    end else if (fire) begin
      m_open = 0; m_sent = 0;
    end else begin
      if (!m_sent && mrdy) m_sent = 1;
      m_age++;
    end
  endtask

  task automatic idle(input bit r);
    step(r, 0, '0, 0, '0, 0, '0, '0, 0, 0, '0);
  endtask

  initial begin
    rst = 1'b1;
    bus.ifu_req_valid = 0; bus.ifu_addr = '0;
    bus.lsu_req_valid = 0; bus.lsu_addr = '0; bus.lsu_we = 0;
    bus.lsu_wdata = '0; bus.lsu_wmask = '0;
    bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_rdata = '0;
    m_open = 0; m_sent = 0; m_owner = 0; m_we = 0; m_wd_chk = 0;
    m_addr = '0; m_wdata = '0; m_wmask = '0; m_age = 0;

    idle(1); idle(1); idle(0);

    // IFU fetch against zero-wait memory.
    step(0, 1, 32'h8000_0000, 0, '0, 0, '0, '0, 0, 0, '0);
    step(0, 0, '0, 0, '0, 0, '0, '0, 1, 0, '0);
    step(0, 0, '0, 0, '0, 0, '0, '0, 0, 1, 32'h0010_0073);
    idle(0);

    // Simultaneous requests: LSU first, held IFU request served next.
    step(0, 1, 32'h8000_0004, 1, 32'h8000_1000, 0, 32'h1111_2222, 4'hF, 0, 0, '0);
    step(0, 1, 32'h8000_0004, 0, '0, 0, '0, '0, 1, 0, '0);
    step(0, 1, 32'h8000_0004, 0, '0, 0, '0, '0, 0, 1, 32'hCAFE_0001);
    step(0, 1, 32'h8000_0004, 0, '0, 0, '0, '0, 0, 0, '0);
    step(0, 0, '0, 0, '0, 0, '0, '0, 1, 0, '0);
    step(0, 0, '0, 0, '0, 0, '0, '0, 0, 1, 32'hCAFE_0002);
    idle(0);

    // LSU store with four stall cycles; stray responses in REQ must be ignored.
    step(0, 0, '0, 1, 32'h8000_2000, 1, 32'hDEAD_BEEF, 4'h3, 0, 0, '0);
    for (int i = 0; i < 4; i++)
      step(0, 1, 32'h8000_0008, 0, 32'h1234_5678, 0, 32'h5555_5555, 4'hC, 0, (i % 2) == 0, 32'hBAD0_0000);
    step(0, 0, '0, 0, '0, 0, '0, '0, 1, 0, '0);
    step(0, 0, '0, 0, '0, 0, '0, '0, 0, 0, '0);
    step(0, 0, '0, 0, '0, 0, '0, '0, 0, 1, 32'h0000_0001);
    idle(0);

    // Reset while waiting in RSP, then a late response in IDLE.
    step(0, 0, '0, 1, 32'h8000_3000, 0, '0, 4'hF, 0, 0, '0);
    step(0, 0, '0, 0, '0, 0, '0, '0, 1, 0, '0);
    idle(1);
    step(0, 0, '0, 0, '0, 0, '0, '0, 0, 1, 32'h7777_7777);
    idle(0);

    // Memory accepts but never answers: timeout build errors out, default build waits.
    step(0, 0, '0, 1, 32'h8000_4000, 0, '0, 4'h0, 0, 0, '0);
    step(0, 0, '0, 0, '0, 0, '0, '0, 1, 0, '0);
    for (int i = 0; i < 1000; i++) idle(0);
    idle(1);
    idle(0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(63) == 0,
           $urandom_range(1) == 0, $urandom,
           $urandom_range(4) < 2, $urandom, $urandom_range(1) == 1,
           $urandom, 4'($urandom),
           $urandom_range(1) == 1, $urandom_range(9) < 3, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single memory port between the IFU (instruction fetch) and LSU (load/store) in the multi-cycle core. Owns the only path to memory; accepts one request at a time, forwards it downstream, and routes the response back to the requester that issued it. Placed between IFU/LSU and the memory/DPI bridge.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles a transaction may stay outstanding before a forced error response. Used only with `ARB_TIMEOUT_EN`; must be at least 1.
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ifu_req_valid`  in  1  fetch request
- `ifu_req_ready`  out  1  fetch request accepted this cycle
- `ifu_addr`  in  32  fetch address
- `ifu_rsp_valid`  out  1  fetch response, 1-cycle pulse
- `ifu_rsp_rdata`  out  32  fetched word
- `ifu_rsp_err`  out  1  fetch response is a timeout error
- `lsu_req_valid`  in  1  load/store request
- `lsu_req_ready`  out  1  load/store request accepted this cycle
- `lsu_addr`  in  32  data address
- `lsu_we`  in  1  1 = store, 0 = load
- `lsu_wdata`  in  32  store data
- `lsu_wmask`  in  4  byte enables for a store
- `lsu_rsp_valid`  out  1  load/store response, 1-cycle pulse
- `lsu_rsp_rdata`  out  32  load data; don't-care for stores
- `lsu_rsp_err`  out  1  load/store response is a timeout error
- `mem_req_valid`  out  1  downstream request
- `mem_req_ready`  in  1  downstream request accepted
- `mem_addr`, `mem_wdata`  out  32  latched address and store data
- `mem_we`  out  1  latched write enable
- `mem_wmask`  out  4  latched byte mask
- `mem_rsp_valid`  in  1  downstream response
- `mem_rsp_rdata`  in  32  downstream read data
- `busy`  out  1  high in any state other than IDLE
- `owner`  out  1  owner of the current transaction: 0 = IFU, 1 = LSU

## Operation
- The FSM has three states: IDLE, REQ, RSP.
- **IDLE**
  - Arbitration uses fixed priority: the LSU beats the IFU.
  - `lsu_req_ready = lsu_req_valid`.
  - `ifu_req_ready = ifu_req_valid & ~lsu_req_valid`.
  - Both ready signals are combinational and are 0 in every state other than IDLE.
  - On acceptance, the winner's address, we, wdata and wmask are latched into the `mem_*` registers.
  - An IFU request always latches `we = 0` and `wmask = 0`.
  - `owner` is set to the winner and the FSM moves to REQ.
- **REQ**
  - `mem_req_valid = 1`. The `mem_*` outputs stay stable until `mem_req_ready`.
  - When `mem_req_ready` is seen, the FSM moves to RSP.
  - Any `mem_rsp_valid` seen in REQ is ignored.
- **RSP**
  - When `mem_rsp_valid` is seen, the owner's `*_rsp_valid = 1` and `*_rsp_rdata = mem_rsp_rdata`.
  - Both are combinational pass-throughs, with `*_rsp_err = 0`. The FSM then moves to IDLE.
  - The non-owner's `rsp_valid` stays 0.
- Only one transaction is outstanding at a time. A requester may hold `req_valid` across cycles; it is accepted on the first IDLE cycle in which it wins.
- A `mem_rsp_valid` seen in IDLE is ignored.

## Timing
- Reset values:
  - state IDLE, `owner` 0, `busy` 0, `mem_req_valid` 0
  - `mem_addr`, `mem_wdata`, `mem_we`, `mem_wmask` all 0
  - all `rsp_valid`, `rsp_err` and `req_ready` 0
  - timeout counter 0
- Reset in the middle of a transaction drops it with no response. The cycle after reset deasserts is IDLE.
- Minimum latency, counted from the acceptance cycle T:
  - `mem_req_valid` at T+1
  - with `mem_req_ready` at T+1, the response can come back no earlier than T+2
  - the next acceptance is possible at T+3
- Back-to-back requests therefore cost at least 3 cycles each. There is no bubble-free pipelining.
- When the IFU and LSU request in the same IDLE cycle, the LSU wins. The IFU is accepted at the next IDLE.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to REQ and increments every cycle in REQ or RSP.
  - If it reaches `TIMEOUT_CYCLES` before completion, the owner gets a 1-cycle `rsp_valid` with `rsp_err = 1` and `rsp_rdata = 0`.
  - `mem_req_valid` drops and the FSM moves to IDLE.
  - If normal completion and the timeout happen in the same cycle, normal completion wins with `err = 0`.
  - A timeout is a fatal indication. A late `mem_rsp_valid` that arrives afterwards falls into the ignored-in-IDLE or ignored-in-REQ rule.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built and both `*_rsp_err` outputs are tied to 0.
  - The FSM waits indefinitely in REQ or RSP.

## Test plan
- **IFU fetch, zero-wait memory:** `ifu_addr` = 0x80000000, memory ready immediately, response 0x00100073 at T+2 → `ifu_rsp_valid` at T+2 with rdata 0x00100073, `busy` low at T+3.
- **Simultaneous requests:** IFU 0x80000004 and LSU load 0x80001000 in the same cycle → LSU accepted first (`owner` = 1, `mem_addr` 0x80001000); IFU accepted at the next IDLE and served second.
- **LSU store with stalls:** `lsu_addr` 0x80002000, wdata 0xDEADBEEF, wmask 0x3, `mem_req_ready` held low for 4 cycles → `mem_*` outputs stable throughout; `lsu_rsp_valid` once, `ifu_rsp_valid` never.
- **Reset mid-transaction:** `rst` in RSP → next cycle IDLE with every output at its reset value; a late `mem_rsp_valid` produces no `rsp_valid`.
- **Timeout (`ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8):** memory never responds → `lsu_rsp_valid` with `err = 1` and rdata 0 exactly 8 cycles after REQ entry, then IDLE.
- **No timeout (macro undefined):** the same stimulus for 1000 cycles → `busy` stays 1 and no response is produced.
